// File: rtl/csa_accum_if.sv
// Operand stream in, resolved group total out; both sides valid/ready.
// slave is the accumulator's view, master is the surrounding logic's view.
interface csa_accum_if #(
  parameter int WIDTH = 4,
  parameter int ACC_W = 8
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [7:0]       out_count;
  logic             out_ovf;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_ovf
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_ovf
  );
endinterface

// File: rtl/csa_accum.sv
// Carry-save group accumulator: one operand/cycle into redundant S/C, one resolve cycle on last.
// Result valid one edge after the last operand; input stalls (in_ready=0) until the result is taken.
module csa_accum #(
  parameter int WIDTH = 4,
  parameter int ACC_W = 8
) (
  input  logic       clk,
  input  logic       rst,
  csa_accum_if.slave bus
);

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    RESOLVE = 2'd1,
    OUTPUT  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] s_q, s_d;
  logic [ACC_W-1:0] c_q, c_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             ovf_st_q, ovf_st_d;
  logic             out_valid_q, out_valid_d;
  logic [ACC_W-1:0] out_sum_q, out_sum_d;
  logic [7:0]       out_count_q, out_count_d;
  logic             out_ovf_q, out_ovf_d;

  logic [ACC_W-1:0] x;
  logic [ACC_W-1:0] maj;
  logic [ACC_W:0]   resolved;
  logic             in_hs;

  assign x        = {{(ACC_W-WIDTH){1'b0}}, bus.in_data};
  assign maj      = (s_q & c_q) | (s_q & x) | (c_q & x);
  assign resolved = {1'b0, s_q} + {1'b0, c_q};
  assign in_hs    = bus.in_valid && (state_q == ACCUM);

  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    c_d         = c_q;
    cnt_d       = cnt_q;
    ovf_st_d    = ovf_st_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;

    case (state_q)
      ACCUM: begin
        if (in_hs) begin
          s_d      = s_q ^ c_q ^ x;
          // The MSB majority bit would shift out of C; all terms are unsigned, so it is real overflow.
          c_d      = {maj[ACC_W-2:0], 1'b0};
          ovf_st_d = ovf_st_q | maj[ACC_W-1];
          cnt_d    = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
          if (bus.in_last) begin
            state_d = RESOLVE;
          end
        end
      end
      RESOLVE: begin
        out_sum_d   = resolved[ACC_W-1:0];
        out_ovf_d   = ovf_st_q | resolved[ACC_W];
        out_count_d = cnt_q;
        out_valid_d = 1'b1;
        state_d     = OUTPUT;
      end
      OUTPUT: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          s_d         = '0;
          c_d         = '0;
          cnt_d       = '0;
          ovf_st_d    = 1'b0;
          state_d     = ACCUM;
        end
      end
      default: begin
        state_d = ACCUM;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ACCUM;
      s_q         <= '0;
      c_q         <= '0;
      cnt_q       <= '0;
      ovf_st_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      c_q         <= c_d;
      cnt_q       <= cnt_d;
      ovf_st_q    <= ovf_st_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign bus.in_ready  = (state_q == ACCUM);
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_count = out_count_q;
  assign bus.out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_csa_accum.sv
// Directed and randomised groups checked every cycle against an integer-sum reference model.
module tb_csa_accum;
  localparam int WIDTH = 4;
  localparam int ACC_W = 8;
  localparam int MOD   = 1 << ACC_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  csa_accum_if #(.WIDTH(WIDTH), .ACC_W(ACC_W)) bus ();

  csa_accum #(.WIDTH(WIDTH), .ACC_W(ACC_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: true integer running sum, and the protocol phase
  // (0 accepting, 1 resolving, 2 presenting a result).
  int m_sum = 0, m_cnt = 0, phase = 0;
  int p_sum = 0, p_cnt = 0, p_ovf = 0;
  int h_sum = 0, h_cnt = 0, h_ovf = 0;
  int r_sum[$], r_cnt[$], r_ovf[$];

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_out_valid", int'(bus.out_valid), 0);
      chk("rst_out_sum",   int'(bus.out_sum),   0);
      chk("rst_out_count", int'(bus.out_count), 0);
      chk("rst_out_ovf",   int'(bus.out_ovf),   0);
      m_sum = 0; m_cnt = 0; phase = 0;
      h_sum = 0; h_cnt = 0; h_ovf = 0;
    end else begin
      chk("in_ready",  int'(bus.in_ready),  int'(phase == 0));
      chk("out_valid", int'(bus.out_valid), int'(phase == 2));
      chk("out_sum",   int'(bus.out_sum),   h_sum);
      chk("out_count", int'(bus.out_count), h_cnt);
      chk("out_ovf",   int'(bus.out_ovf),   h_ovf);
      case (phase)
        0: if (bus.in_valid) begin
          m_sum += int'(bus.in_data);
          m_cnt++;
          if (bus.in_last) begin
            p_sum = m_sum % MOD;
            p_cnt = (m_cnt > 255) ? 255 : m_cnt;
            p_ovf = int'(m_sum >= MOD);
            phase = 1;
          end
        end
        1: begin
          h_sum = p_sum; h_cnt = p_cnt; h_ovf = p_ovf;
          phase = 2;
        end
        default: if (bus.out_ready) begin
          r_sum.push_back(h_sum);
          r_cnt.push_back(h_cnt);
          r_ovf.push_back(h_ovf);
          m_sum = 0; m_cnt = 0;
          phase = 0;
        end
      endcase
    end
  end

  task automatic send(input logic [WIDTH-1:0] d, input logic l);
    int  tmo;
    logic hs;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    tmo = 0;
    hs  = 1'b0;
    while (!hs && tmo < 200) begin
      @(negedge clk);
      hs = bus.in_ready;
      @(posedge clk);
      #1;
      tmo++;
    end
    if (!hs) chk("send_timeout", 0, 1);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic idle_garbage();
    bus.in_valid = 1'b0;
    bus.in_data  = 4'($urandom_range(0, 15));
    bus.in_last  = 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
    bus.in_last  = 1'b0;
  endtask

  task automatic wait_res(input int n);
    int tmo;
    tmo = 0;
    while (r_sum.size() < n && tmo < 2000) begin
      @(posedge clk);
      #1;
      tmo++;
    end
    if (r_sum.size() < n) chk("result_timeout", r_sum.size(), n);
  endtask

  task automatic expect_res(input int i, input int s, input int c, input int o);
    chk("res_present", int'(r_sum.size() > i), 1);
    if (r_sum.size() > i) begin
      chk($sformatf("lit_sum[%0d]", i),   r_sum[i], s);
      chk($sformatf("lit_count[%0d]", i), r_cnt[i], c);
      chk($sformatf("lit_ovf[%0d]", i),   r_ovf[i], o);
    end
  endtask

  bit done = 1'b0;

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // in_last and data with in_valid low must be ignored
    bus.in_last = 1'b1;
    bus.in_data = 4'hF;
    repeat (3) @(posedge clk);
    #1 bus.in_last = 1'b0;

    send(4'd3, 1'b0); send(4'd5, 1'b0); send(4'd7, 1'b1);
    wait_res(1);
    expect_res(0, 15, 3, 0);

    for (int i = 0; i < 17; i++) send(4'd15, 1'(i == 16));
    wait_res(2);
    expect_res(1, 255, 17, 0);

    for (int i = 0; i < 18; i++) send(4'd15, 1'(i == 17));
    wait_res(3);
    expect_res(2, 14, 18, 1);

    // Result held under backpressure
    bus.out_ready = 1'b0;
    send(4'd9, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    chk("hold_out_valid", int'(bus.out_valid), 1);
    chk("hold_in_ready",  int'(bus.in_ready),  0);
    chk("hold_out_sum",   int'(bus.out_sum),   9);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("drop_out_valid", int'(bus.out_valid), 0);
    chk("kept_out_sum",   int'(bus.out_sum),   9);
    wait_res(4);
    expect_res(3, 9, 1, 0);

    // Back-to-back groups with in_valid held across the boundary
    send(4'd1, 1'b0); send(4'd2, 1'b1); send(4'd4, 1'b0); send(4'd8, 1'b1);
    wait_res(6);
    expect_res(4, 3, 2, 0);
    expect_res(5, 12, 2, 0);

    // Reset mid-group discards the partial sum
    send(4'd6, 1'b0); send(4'd6, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    send(4'd2, 1'b1);
    wait_res(7);
    expect_res(6, 2, 1, 0);

    // Count saturation past 255 operands
    for (int i = 0; i < 300; i++) send(4'd1, 1'(i == 299));
    wait_res(8);
    expect_res(7, 44, 255, 1);

    fork
      begin
        for (int g = 0; g < 1000; g++) begin
          int len;
          len = $urandom_range(1, 40);
          for (int i = 0; i < len; i++) begin
            while ($urandom_range(0, 3) == 0) idle_garbage();
            send(4'($urandom_range(0, 15)), 1'(i == len - 1));
          end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        bus.out_ready = 1'b1;
      end
    join
    wait_res(1008);
    chk("group_total", r_sum.size(), 1008);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation exceeded its cycle budget");
    $fatal(1);
  end

endmodule
